// File: rtl/rock_scheduler.sv
// rock_scheduler: closed-loop rocking-profile sequencer driven by stress-trend flags
// Inputs : clk, reset (async, active-high), start, stop, eval_tick, gedaald (decreased), gelijk (unchanged)
// Outputs: motor_en, mode (0 = off, 1..NUM_MODES), calm, alarm (sticky), state (debug encoding)
module rock_scheduler #(
  parameter int NUM_MODES    = 5,
  parameter int SETTLE_TICKS = 2,
  parameter int CALM_TICKS   = 4,
  parameter int SAME_LIMIT   = 3,
  parameter int MAX_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       eval_tick,
  input  logic       gedaald,
  input  logic       gelijk,
  output logic       motor_en,
  output logic [2:0] mode,
  output logic       calm,
  output logic       alarm,
  output logic [2:0] state
);
  typedef enum logic [2:0] {IDLE = 3'd0, SETTLE = 3'd1, EVAL = 3'd2, NEXT = 3'd3, CALM = 3'd4, ALARM = 3'd5} state_t;
  state_t     state_q, state_d;
  logic [2:0] mode_q, mode_d, last_good_q, last_good_d;
  logic       motor_en_q, motor_en_d, calm_q, calm_d, alarm_q, alarm_d;
  logic [3:0] settle_cnt_q, settle_cnt_d, calm_cnt_q, calm_cnt_d;
  logic [3:0] same_cnt_q, same_cnt_d, cycle_cnt_q, cycle_cnt_d;
  logic       dec, same, rose;
  assign dec  = eval_tick & gedaald;
  assign same = eval_tick & ~gedaald & gelijk;
  assign rose = eval_tick & ~gedaald & ~gelijk;
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    last_good_d  = last_good_q;
    motor_en_d   = motor_en_q;
    calm_d       = calm_q;
    alarm_d      = alarm_q;
    settle_cnt_d = settle_cnt_q;
    calm_cnt_d   = calm_cnt_q;
    same_cnt_d   = same_cnt_q;
    cycle_cnt_d  = cycle_cnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d      = SETTLE;
        mode_d       = 3'd1;
        motor_en_d   = 1'b1;
        cycle_cnt_d  = '0;
        settle_cnt_d = '0;
      end
      SETTLE: if (eval_tick) begin
        settle_cnt_d = settle_cnt_q + 4'd1;
        if (settle_cnt_q + 4'd1 == 4'(SETTLE_TICKS)) begin
          state_d      = EVAL;
          settle_cnt_d = '0;
          calm_cnt_d   = '0;
          same_cnt_d   = '0;
        end
      end
      EVAL: begin
        if (dec) begin
          calm_cnt_d  = calm_cnt_q + 4'd1;
          same_cnt_d  = '0;
          last_good_d = mode_q;
          if (calm_cnt_q + 4'd1 == 4'(CALM_TICKS)) begin
            state_d    = CALM;
            mode_d     = '0;
            motor_en_d = 1'b0;
            calm_d     = 1'b1;
          end
        end else if (same) begin
          same_cnt_d = same_cnt_q + 4'd1;
          calm_cnt_d = '0;
          if (same_cnt_q + 4'd1 == 4'(SAME_LIMIT)) state_d = NEXT;
        end else if (rose) state_d = NEXT;
      end
      NEXT: begin
        state_d      = SETTLE;
        settle_cnt_d = '0;
        if (mode_q < 3'(NUM_MODES)) mode_d = mode_q + 3'd1;
        else if (cycle_cnt_q + 4'd1 == 4'(MAX_CYCLES)) begin
          state_d    = ALARM;
          mode_d     = '0;
          motor_en_d = 1'b0;
          alarm_d    = 1'b1;
        end else begin
          mode_d      = 3'd1;
          cycle_cnt_d = cycle_cnt_q + 4'd1;
        end
      end
      CALM: if (rose) begin
        state_d      = SETTLE;
        mode_d       = last_good_q;
        motor_en_d   = 1'b1;
        calm_d       = 1'b0;
        cycle_cnt_d  = '0;
        settle_cnt_d = '0;
      end
      ALARM: ;
      default: state_d = IDLE;
    endcase
    if (stop) begin
      state_d      = IDLE;
      mode_d       = '0;
      last_good_d  = 3'd1;
      motor_en_d   = 1'b0;
      calm_d       = 1'b0;
      alarm_d      = 1'b0;
      settle_cnt_d = '0;
      calm_cnt_d   = '0;
      same_cnt_d   = '0;
      cycle_cnt_d  = '0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      mode_q       <= '0;
      last_good_q  <= 3'd1;
      motor_en_q   <= 1'b0;
      calm_q       <= 1'b0;
      alarm_q      <= 1'b0;
      settle_cnt_q <= '0;
      calm_cnt_q   <= '0;
      same_cnt_q   <= '0;
      cycle_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      last_good_q  <= last_good_d;
      motor_en_q   <= motor_en_d;
      calm_q       <= calm_d;
      alarm_q      <= alarm_d;
      settle_cnt_q <= settle_cnt_d;
      calm_cnt_q   <= calm_cnt_d;
      same_cnt_q   <= same_cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
    end
  end
  assign state    = state_q;
  assign mode     = mode_q;
  assign motor_en = motor_en_q;
  assign calm     = calm_q;
  assign alarm    = alarm_q;
endmodule

// File: doc/rock_scheduler.md
Name: rock_scheduler

Overview:
Closed-loop sequencer for the rocking motor. It steps through rocking profiles and uses the stress block's "gedaald" (stress decreased) and "gelijk" (stress unchanged) flags to judge each profile. A profile that works is kept; a profile that does not is replaced by the next one. It raises "calm" when the baby settles and "alarm" when every profile has failed MAX_CYCLES times. It sits between the stress block and the motor driver.

Parameters:
NUM_MODES, 5, number of rocking profiles, encoded 1..NUM_MODES (legal range 1..7); mode 0 = motor off
SETTLE_TICKS, 2, eval ticks to wait after a profile change before judging it (1..15)
CALM_TICKS, 4, consecutive "decreased" evaluations needed to declare calm (1..15)
SAME_LIMIT, 3, consecutive "unchanged" evaluations tolerated before changing profile (1..15)
MAX_CYCLES, 2, full passes through all profiles before alarm (1..15)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  level; request rocking (crying detected)
stop  in  1  level; abort, return to idle
eval_tick  in  1  one-clk pulse per evaluation period (the 12-period strobe, resynchronised to clk)
gedaald  in  1  stress decreased, valid when eval_tick=1
gelijk  in  1  stress unchanged, valid when eval_tick=1
motor_en  out  1  motor driver enable
mode  out  3  active rocking profile; 0 when motor off
calm  out  1  baby calm (state CALM)
alarm  out  1  all profiles failed; sticky
state  out  3  debug: IDLE=0 SETTLE=1 EVAL=2 NEXT=3 CALM=4 ALARM=5

Behaviour:
- All outputs are registered. Reset (asynchronous) values: state=IDLE, mode=0, motor_en=0, calm=0, alarm=0. Internal counters (settle_cnt, calm_cnt, same_cnt, cycle_cnt) reset to 0; last_good resets to 1.
- Priority order: reset > stop > state logic. While stop=1, the next edge forces IDLE with mode=0, motor_en=0, calm=0, alarm=0 and all counters cleared. The block stays in IDLE while stop is held.
- Flags are read only in a cycle where eval_tick=1. If gedaald and gelijk are both 1, gedaald wins. "Rose" means eval_tick=1 with gedaald=0 and gelijk=0.
- IDLE: if start=1, go to SETTLE next edge with mode=1, motor_en=1, cycle_cnt=0.
- SETTLE: settle_cnt increments on each eval_tick. On the tick that makes the count equal SETTLE_TICKS, go to EVAL, clear settle_cnt, calm_cnt and same_cnt. Flag values are ignored in SETTLE.
- EVAL, on eval_tick:
  - gedaald: calm_cnt++, same_cnt=0, last_good=mode. If calm_cnt+1==CALM_TICKS, go to CALM.
  - gelijk only: same_cnt++, calm_cnt=0. If same_cnt+1==SAME_LIMIT, go to NEXT.
  - rose: go to NEXT immediately.
- NEXT (exactly one cycle):
  - If mode<NUM_MODES: mode=mode+1.
  - Otherwise mode wraps to 1 and cycle_cnt++. If cycle_cnt+1==MAX_CYCLES, go to ALARM instead.
  - Non-alarm exit is to SETTLE.
- CALM: motor_en=0, mode=0, calm=1.
  - On a rose tick: go to SETTLE with mode=last_good, motor_en=1, calm=0, cycle_cnt=0.
  - gedaald or gelijk ticks: stay in CALM.
- ALARM: motor_en=0, mode=0, alarm=1. Exit only via stop or reset.
- start is ignored outside IDLE. Deasserting start does not stop rocking; only stop does.
- motor_en=1 exactly in SETTLE, EVAL and NEXT. mode is never 0 while motor_en=1.
- Asserting reset mid-operation clears everything asynchronously. After release, the block waits in IDLE for start.

Test Plan:
- Reset, then start=1, then 2 eval_ticks (flags ignored), then 4 ticks with gedaald=1 -> mode=1 throughout, state goes SETTLE->EVAL->CALM, calm=1, motor_en=0, mode=0 one clk after the 4th tick.
- From EVAL in mode 1, 3 ticks with gelijk=1 -> NEXT for one cycle, then SETTLE with mode=2. A single gelijk tick followed by a gedaald tick resets same_cnt (verify no profile change).
- Rose tick in EVAL for each profile, default parameters -> mode steps 1,2,3,4,5,1,...,5. At the 2nd wrap, alarm=1, state=5, motor_en=0. A later start=1 has no effect; stop=1 returns to IDLE with alarm=0.
- Enter CALM with last_good=3, then a rose tick -> SETTLE with mode=3, motor_en=1, calm=0.
- gedaald=1 and gelijk=1 on the same tick -> treated as decreased (calm_cnt increments). Flags toggling with eval_tick=0 -> no state change.
- Assert stop during SETTLE, and separately assert reset asynchronously mid-EVAL -> outputs cleared (all 0, state=IDLE); a new start restarts at mode=1.
